// File: rtl/writeback_arbiter_if.sv
// Load/ALU result handshake bundle feeding the writeback arbiter.
// Ports: alu_valid/alu_ready/alu_rd/alu_data (ALU channel) and ld_valid/ld_ready/ld_rd/ld_data (load channel).
// master = producer side (drives valids and payloads), slave = arbiter side (drives readies).
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU results and a FIFO of load results onto one register-file write port.
// Latency: ALU accept -> write 1 cycle; load accept -> earliest write 2 cycles (no bypass).
// Backpressure: ld_ready from registered FIFO count; alu_ready drops only when the FIFO is starved.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport), wen_o/write_sel_o/write_data_o
// (registered write port), fifo_count_o (load FIFO occupancy).
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  writeback_arbiter_if.slave       bus,
  output logic                     wen_o,
  output logic [4:0]               write_sel_o,
  output logic [31:0]              write_data_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wen_q, wen_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   data_q, data_d;

  logic          fifo_empty;
  logic          starved;
  logic          push;
  logic          pop;
  logic          alu_xfer;
  logic [36:0]   head;

  assign fifo_empty = (count_q == '0);
  assign starved    = (starve_q == SW'(STARVE_LIMIT));
  assign head       = mem_q[rd_ptr_q];

  // Readies are forced low while reset is asserted; ld_ready looks only at
  // the registered count, so a pop this cycle does not open a slot until next cycle.
  assign bus.ld_ready  = rst_ni && (count_q < CW'(DEPTH));
  assign bus.alu_ready = rst_ni && (fifo_empty || !starved);

  assign push     = bus.ld_valid && bus.ld_ready;
  assign alu_xfer = bus.alu_valid && bus.alu_ready;
  // The FIFO drains whenever the ALU is idle, or unconditionally once starved.
  assign pop      = rst_ni && !fifo_empty && (starved || !bus.alu_valid);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    wen_d    = 1'b0;
    sel_d    = sel_q;
    data_d   = data_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_xfer && !starved) begin
      starve_d = starve_q + SW'(1);
    end

    // pop and alu_xfer are mutually exclusive by construction. Writes to x0
    // still update sel/data but never raise the enable.
    if (alu_xfer) begin
      wen_d  = (bus.alu_rd != 5'd0);
      sel_d  = bus.alu_rd;
      data_d = bus.alu_data;
    end else if (pop) begin
      wen_d  = (head[36:32] != 5'd0);
      sel_d  = head[36:32];
      data_d = head[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
    end
  end

  // Payload storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {bus.ld_rd, bus.ld_data};
  end

  assign wen_o        = wen_q;
  assign write_sel_o  = sel_q;
  assign write_data_o = data_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_wen, b_wen;
  logic [4:0]  a_sel, b_sel;
  logic [31:0] a_dat, b_dat;
  logic [2:0]  a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  writeback_arbiter_if ifa();
  writeback_arbiter_if ifb();

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa),
    .wen_o(a_wen), .write_sel_o(a_sel), .write_data_o(a_dat), .fifo_count_o(a_cnt)
  );

  // Second instance with a raised starvation limit so the FIFO can fill.
  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(7)) u_dut_big (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb),
    .wen_o(b_wen), .write_sel_o(b_sel), .write_data_o(b_dat), .fifo_count_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        exp_rdy;
    logic        exp_wen;
    logic        chk_bus;
    logic [4:0]  exp_sel;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.alu_valid = 1'b0; ifa.alu_rd = '0; ifa.alu_data = '0;
    ifa.ld_valid  = 1'b0; ifa.ld_rd  = '0; ifa.ld_data  = '0;
    ifb.alu_valid = 1'b0; ifb.alu_rd = '0; ifb.alu_data = '0;
    ifb.ld_valid  = 1'b0; ifb.ld_rd  = '0; ifb.ld_data  = '0;
  endtask

  initial begin
    logic [4:0]  exp_sel_s [6];
    logic        exp_rdy_s [6];
    int          alu_idx;
    bit          popped;

    tbl[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b1, 1'b1, 5'd5,  32'h0000_1234};
    tbl[1] = '{1'b0, 5'd9,  32'h0000_ABCD, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_1234};
    tbl[2] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
    tbl[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd1,  32'h0000_0000};
    tbl[5] = '{1'b1, 5'd2,  32'h5A5A_A5A5, 1'b1, 1'b1, 1'b1, 5'd2,  32'h5A5A_A5A5};
    tbl[6] = '{1'b0, 5'd3,  32'h1111_1111, 1'b1, 1'b0, 1'b1, 5'd2,  32'h5A5A_A5A5};

    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_wen",       32'(a_wen),         32'd0);
    chk("rst_sel",       32'(a_sel),         32'd0);
    chk("rst_data",      a_dat,              32'd0);
    chk("rst_count",     32'(a_cnt),         32'd0);
    chk("rst_alu_ready", 32'(ifa.alu_ready), 32'd0);
    chk("rst_ld_ready",  32'(ifa.ld_ready),  32'd0);
    rst_n = 1'b1;
    tick();

    // ALU-only vectors on an empty FIFO
    for (int i = 0; i < 7; i++) begin
      ifa.alu_valid = tbl[i].v;
      ifa.alu_rd    = tbl[i].rd;
      ifa.alu_data  = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_alu_ready", i), 32'(ifa.alu_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_wen", i), 32'(a_wen), 32'(tbl[i].exp_wen));
      if (tbl[i].chk_bus) begin
        chk($sformatf("vec%0d_sel", i),  32'(a_sel), 32'(tbl[i].exp_sel));
        chk($sformatf("vec%0d_data", i), a_dat,      tbl[i].exp_dat);
      end
    end
    idle_all();

    // Load only: accept, count 1 next cycle, write the cycle after.
    ifa.ld_valid = 1'b1; ifa.ld_rd = 5'd7; ifa.ld_data = 32'hDEAD_BEEF;
    #1;
    chk("ld_ready_empty", 32'(ifa.ld_ready), 32'd1);
    tick();
    ifa.ld_valid = 1'b0;
    chk("ld_count_n1", 32'(a_cnt), 32'd1);
    chk("ld_wen_n1",   32'(a_wen), 32'd0);
    tick();
    chk("ld_wen_n2",   32'(a_wen), 32'd1);
    chk("ld_sel_n2",   32'(a_sel), 32'd7);
    chk("ld_data_n2",  a_dat,      32'hDEAD_BEEF);
    chk("ld_count_n2", 32'(a_cnt), 32'd0);
    tick();
    chk("ld_wen_n3",   32'(a_wen), 32'd0);

    // Starvation: load queued alongside an ALU write, ALU then held busy.
    ifa.alu_valid = 1'b1; ifa.alu_rd = 5'd10; ifa.alu_data = 32'hA0;
    ifa.ld_valid  = 1'b1; ifa.ld_rd  = 5'd20; ifa.ld_data  = 32'hCAFE;
    tick();
    ifa.ld_valid = 1'b0;
    chk("stv_first_sel", 32'(a_sel), 32'd10);
    chk("stv_count",     32'(a_cnt), 32'd1);
    exp_rdy_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_sel_s = '{5'd11, 5'd12, 5'd13, 5'd20, 5'd14, 5'd15};
    alu_idx = 0;
    for (int k = 0; k < 6; k++) begin
      ifa.alu_rd   = 5'(11 + alu_idx);
      ifa.alu_data = 32'(32'h100 + alu_idx);
      #1;
      chk($sformatf("stv%0d_alu_ready", k), 32'(ifa.alu_ready), 32'(exp_rdy_s[k]));
      tick();
      chk($sformatf("stv%0d_wen", k), 32'(a_wen), 32'd1);
      chk($sformatf("stv%0d_sel", k), 32'(a_sel), 32'(exp_sel_s[k]));
      if (exp_rdy_s[k]) alu_idx++;
      if (k == 3) begin
        chk("stv_load_data",  a_dat,      32'hCAFE);
        chk("stv_count_drained", 32'(a_cnt), 32'd0);
      end
    end
    idle_all();
    tick();

    // Full FIFO on the high-limit instance.
    ifb.alu_valid = 1'b1; ifb.alu_rd = 5'd3; ifb.alu_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      ifb.ld_valid = 1'b1; ifb.ld_rd = 5'(21 + i); ifb.ld_data = 32'(32'h500 + i);
      #1;
      chk($sformatf("full_push%0d_ready", i), 32'(ifb.ld_ready), 32'd1);
      tick();
    end
    ifb.ld_rd = 5'd25; ifb.ld_data = 32'h504;
    #1;
    chk("full_count",    32'(b_cnt),         32'd4);
    chk("full_ld_ready", 32'(ifb.ld_ready),  32'd0);
    popped = 1'b0;
    for (int c = 0; c < 20 && !popped; c++) begin
      if (!ifb.alu_ready) begin
        popped = 1'b1;
        chk("full_ready_at_pop", 32'(ifb.ld_ready), 32'd0);
      end else begin
        chk($sformatf("full_hold%0d_count", c), 32'(b_cnt), 32'd4);
      end
      tick();
    end
    if (!popped) begin
      total++; bad++;
      $display("FAIL full_pop_timeout actual=no_pop required=pop_within_20");
    end
    chk("full_pop_sel",    32'(b_sel),        32'd21);
    chk("full_pop_count",  32'(b_cnt),        32'd3);
    chk("full_reopen",     32'(ifb.ld_ready), 32'd1);
    tick();
    ifb.ld_valid = 1'b0;
    chk("full_5th_count",  32'(b_cnt),        32'd4);
    ifb.alu_valid = 1'b0;

    // Reset mid-run with three queued loads.
    ifa.alu_valid = 1'b1; ifa.alu_rd = 5'd4; ifa.alu_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      ifa.ld_valid = 1'b1; ifa.ld_rd = 5'(8 + i); ifa.ld_data = 32'(32'h800 + i);
      tick();
    end
    chk("mid_count_before", 32'(a_cnt), 32'd3);
    chk("mid_wen_before",   32'(a_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_count_rst",     32'(a_cnt),         32'd0);
    chk("mid_wen_rst",       32'(a_wen),         32'd0);
    chk("mid_alu_ready_rst", 32'(ifa.alu_ready), 32'd0);
    chk("mid_ld_ready_rst",  32'(ifa.ld_ready),  32'd0);
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d_wen", i),   32'(a_wen), 32'd0);
      chk($sformatf("post_rst%0d_count", i), 32'(a_cnt), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
